// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the execute-stage memory port.
// Answers one load or store per cycle. Loads return in the request cycle
// from a word-organised RAM (one byte-wide bank per lane) or from a
// 16-byte MMIO window that holds a console TX FIFO and a 64-bit mtime.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   adr_v_i          request valid
//   adr_i            byte address
//   is_store_i       1 = store, 0 = load
//   store_data_i     right-aligned store data
//   access_size_i    one-hot size: 001 byte, 010 half, 100 word
//   load_data_o      aligned word containing adr_i (combinational)
//   access_fault_o   valid request to an unmapped address (combinational)
//   tx_valid_o       TX FIFO head valid
//   tx_data_o        TX FIFO head byte
//   tx_ready_i       consumer accepts the head this cycle
//
// MMIO word offsets: 0 TXDATA, 1 TXSTAT {ovf, full, empty, count[5:0]},
// 2 MTIME_LO, 3 MTIME_HI.

// One byte lane of the RAM: asynchronous read, write on the clock edge.
// Contents are never reset.
module dmem_lane #(
   parameter int DEPTH = 1024,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] idx,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

module dmem_responder #(
   parameter int              XLEN       = 32,
   parameter int              RAM_WORDS  = 1024,
   parameter logic [XLEN-1:0] MMIO_BASE  = 32'h1000_0000,
   parameter int              FIFO_DEPTH = 8,
   parameter int              TICK_DIV   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            adr_v_i,
   input  logic [XLEN-1:0] adr_i,
   input  logic            is_store_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [2:0]      access_size_i,
   output logic [XLEN-1:0] load_data_o,
   output logic            access_fault_o,
   output logic            tx_valid_o,
   output logic [7:0]      tx_data_o,
   input  logic            tx_ready_i
);

   localparam int NUM_LANES = XLEN / 8;
   localparam int RAW       = $clog2(RAM_WORDS);
   localparam int PW        = $clog2(FIFO_DEPTH);
   localparam int CW        = PW + 1;
   localparam int PSW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(RAM_WORDS * 4);

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_TXSTAT = 2'd1;
   localparam logic [1:0] OFF_MTLO   = 2'd2;
   localparam logic [1:0] OFF_MTHI   = 2'd3;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic       ram_hit;
   logic       mmio_hit;
   logic [1:0] off;

   assign ram_hit  = adr_i < RAM_BYTES;
   // RAM takes priority so an overlapping MMIO_BASE can never double-decode.
   assign mmio_hit = ~ram_hit & (adr_i[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
   assign off      = adr_i[3:2];

   assign access_fault_o = adr_v_i & ~ram_hit & ~mmio_hit;

   // ------------------------------------------------------------------
   // Size decode: byte-lane enables. Illegal (non one-hot) sizes leave
   // every enable low, so they write nothing anywhere.
   // ------------------------------------------------------------------
   logic                 size_ok;
   logic [NUM_LANES-1:0] be;

   always_comb begin
      size_ok = 1'b0;
      be      = '0;
      case (access_size_i)
         3'b001: begin
            size_ok = 1'b1;
            be      = 4'b0001 << adr_i[1:0];
         end
         3'b010: begin
            size_ok = 1'b1;
            be      = adr_i[1] ? 4'b1100 : 4'b0011;
         end
         3'b100: begin
            size_ok = 1'b1;
            be      = 4'b1111;
         end
         default: begin
            size_ok = 1'b0;
            be      = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // RAM: data is replicated across lanes (byte x4, half x2), so every
   // enabled lane already holds the right byte without a variable shift.
   // ------------------------------------------------------------------
   logic                            ram_we;
   logic [RAW-1:0]                  ram_idx;
   logic [NUM_LANES-1:0][7:0]       lane_wdata;
   logic [NUM_LANES-1:0][7:0]       lane_rdata;

   assign ram_we  = adr_v_i & is_store_i & ram_hit;
   assign ram_idx = adr_i[RAW+1:2];

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign lane_wdata[l] =
         (access_size_i == 3'b001) ? store_data_i[7:0] :
         (access_size_i == 3'b010) ? store_data_i[8*(l%2) +: 8] :
                                     store_data_i[8*l +: 8];

      dmem_lane #(.DEPTH(RAM_WORDS)) u_lane (
         .clk   (clk),
         .we    (ram_we & be[l]),
         .idx   (ram_idx),
         .wdata (lane_wdata[l]),
         .rdata (lane_rdata[l])
      );
   end

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          ovf_clr;

   assign full  = (count == CW'(FIFO_DEPTH));
   assign empty = (count == '0);

   // Word/half/byte stores all push store_data_i[7:0]: after lane
   // replication that is the byte sitting in lane adr[1:0].
   assign push_req = adr_v_i & is_store_i & mmio_hit & (off == OFF_TXDATA) & size_ok;
   // Full is judged on the pre-edge count: a same-cycle pop does not
   // make room for the push.
   assign push     = push_req & ~full;
   assign pop      = ~empty & tx_ready_i;
   assign ovf_clr  = adr_v_i & is_store_i & mmio_hit & (off == OFF_TXSTAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push_req & full) ovf <= 1'b1;
         else if (ovf_clr)    ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= store_data_i[7:0];
   end

   assign tx_valid_o = ~empty;
   // Storage is not reset; masking with empty gives a zero head after reset.
   assign tx_data_o  = empty ? 8'h00 : fifo_mem[rd_ptr];

   // ------------------------------------------------------------------
   // mtime with prescaler
   // ------------------------------------------------------------------
   logic [PSW-1:0] presc;
   logic [63:0]    mtime;
   logic           tick;

   assign tick = (presc == PSW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         mtime <= '0;
      end else if (tick) begin
         presc <= '0;
         mtime <= mtime + 64'd1;
      end else begin
         presc <= presc + PSW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Load data
   // ------------------------------------------------------------------
   logic [XLEN-1:0] txstat;

   assign txstat = XLEN'({ovf, full, empty, 6'(count)});

   always_comb begin
      load_data_o = '0;
      if (adr_v_i) begin
         if (ram_hit) begin
            load_data_o = lane_rdata;
         end else if (mmio_hit) begin
            case (off)
               OFF_TXSTAT: load_data_o = txstat;
               OFF_MTLO:   load_data_o = mtime[31:0];
               OFF_MTHI:   load_data_o = mtime[63:32];
               default:    load_data_o = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a table of RAM/decode vectors plus
// hand-written sequences for the FIFO, overflow, mtime and reset behaviour.
module tb_dmem_responder;

   localparam logic [31:0] TXD = 32'h1000_0000;
   localparam logic [31:0] TXS = 32'h1000_0004;
   localparam logic [31:0] MLO = 32'h1000_0008;
   localparam logic [31:0] MHI = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        adr_v = 1'b0;
   logic [31:0] adr = '0;
   logic        is_store = 1'b0;
   logic [31:0] store_data = '0;
   logic [2:0]  access_size = 3'b100;
   logic [31:0] load_data;
   logic        access_fault;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   dmem_responder #(.TICK_DIV(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .adr_v_i        (adr_v),
      .adr_i          (adr),
      .is_store_i     (is_store),
      .store_data_i   (store_data),
      .access_size_i  (access_size),
      .load_data_o    (load_data),
      .access_fault_o (access_fault),
      .tx_valid_o     (tx_valid),
      .tx_data_o      (tx_data),
      .tx_ready_i     (tx_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] adr;
      logic        st;
      logic [31:0] wd;
      logic [2:0]  sz;
      logic        chk_ld;
      logic [31:0] ld;
      logic        flt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v, input logic [31:0] a, input logic st,
                               input logic [31:0] wd, input logic [2:0] sz,
                               input logic chk_ld, input logic [31:0] ld, input logic flt);
      vec_t t;
      t = '{v, a, st, wd, sz, chk_ld, ld, flt};
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one request cycle at the falling edge; sample 1 ns later.
   task automatic drive(input logic v, input logic [31:0] a, input logic st,
                        input logic [31:0] d, input logic [2:0] sz, input logic rdy);
      @(negedge clk);
      adr_v = v; adr = a; is_store = st; store_data = d; access_size = sz; tx_ready = rdy;
      #1;
   endtask

   task automatic ld(input logic [31:0] a);
      drive(1'b1, a, 1'b0, 32'h0, 3'b100, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b100, rdy);
   endtask

   task automatic push(input logic [7:0] b);
      drive(1'b1, TXD, 1'b1, {24'h0, b}, 3'b001, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] lo;
      bit          seen;

      // ---------------- reset state ----------------
      ld(TXS);
      check("rst_txstat", load_data, 32'h040);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      ld(MLO);
      check("rst_mtime_lo", load_data, 0);
      @(negedge clk);
      reset = 1'b0;
      adr_v = 1'b0;

      // ---------------- mtime rate: 40 edges / 4 = 10 ----------------
      repeat (40) @(posedge clk);
      ld(MLO);
      check("mtime_40cyc", load_data, 32'd10);

      // ---------------- RAM / decode table ----------------
      add(1, 32'h10, 1, 32'hDEAD_BEEF, 3'b100, 0, 0, 0);
      add(1, 32'h12, 1, 32'h0000_0055, 3'b001, 0, 0, 0);
      add(1, 32'h10, 0, 0, 3'b100, 1, 32'hDE55_BEEF, 0);
      add(1, 32'h12, 0, 0, 3'b001, 1, 32'hDE55_BEEF, 0);
      add(1, 32'h12, 1, 32'h0000_1234, 3'b010, 0, 0, 0);
      add(1, 32'h10, 0, 0, 3'b100, 1, 32'h1234_BEEF, 0);
      add(1, 32'h11, 1, 32'hFFFF_ABCD, 3'b010, 0, 0, 0);
      add(1, 32'h13, 0, 0, 3'b100, 1, 32'h1234_ABCD, 0);
      add(1, 32'h13, 1, 32'hFFFF_FF77, 3'b001, 0, 0, 0);
      add(1, 32'h10, 1, 32'hFFFF_FFFF, 3'b011, 0, 0, 0);
      add(1, 32'h10, 1, 32'h0000_0000, 3'b000, 0, 0, 0);
      add(1, 32'h10, 0, 0, 3'b100, 1, 32'h7734_ABCD, 0);
      add(1, 32'h16, 1, 32'hCAFE_F00D, 3'b100, 0, 0, 0);
      add(1, 32'h14, 0, 0, 3'b100, 1, 32'hCAFE_F00D, 0);
      add(1, 32'h10, 0, 0, 3'b100, 1, 32'h7734_ABCD, 0);
      add(1, 32'hFFC, 1, 32'h0102_0304, 3'b100, 0, 0, 0);
      add(1, 32'hFFE, 0, 0, 3'b100, 1, 32'h0102_0304, 0);
      add(1, 32'h1000, 0, 0, 3'b100, 1, 32'h0, 1);
      add(1, 32'h2000_0010, 1, 32'h1111_1111, 3'b100, 1, 32'h0, 1);
      add(1, 32'h2000_0000, 1, 32'h0000_005A, 3'b001, 1, 32'h0, 1);
      add(1, 32'h2000_0010, 0, 0, 3'b100, 1, 32'h0, 1);
      add(1, 32'h10, 0, 0, 3'b100, 1, 32'h7734_ABCD, 0);
      add(1, TXS, 0, 0, 3'b100, 1, 32'h040, 0);
      add(0, 32'h10, 0, 0, 3'b100, 1, 32'h0, 0);
      add(0, 32'h2000_0000, 0, 0, 3'b100, 1, 32'h0, 0);
      add(1, 32'h1000_0010, 0, 0, 3'b100, 1, 32'h0, 1);
      add(1, 32'h0FFF_FFFC, 0, 0, 3'b100, 1, 32'h0, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].adr, vecs[i].st, vecs[i].wd, vecs[i].sz, 1'b0);
         if (vecs[i].chk_ld) check($sformatf("vec%0d_load", i), load_data, vecs[i].ld);
         check($sformatf("vec%0d_fault", i), access_fault, vecs[i].flt);
      end

      // ---------------- FIFO push / drain ----------------
      push(8'h41);
      check("push_latency_valid", tx_valid, 0);
      ld(TXS);
      check("txstat_after_a", load_data, 32'h001);
      check("head_a_valid", tx_valid, 1);
      check("head_a", tx_data, 8'h41);
      drive(1'b1, TXD, 1'b1, 32'hAAAA_AA42, 3'b100, 1'b0);
      drive(1'b1, TXD + 32'd2, 1'b1, 32'h0000_5543, 3'b010, 1'b0);
      ld(TXS);
      check("txstat_abc", load_data, 32'h003);
      check("head_stable", tx_data, 8'h41);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         check($sformatf("drain%0d_valid", i), tx_valid, 1);
         check($sformatf("drain%0d_data", i), tx_data, 32'h41 + i);
      end
      ld(TXS);
      check("drained_valid", tx_valid, 0);
      check("drained_txstat", load_data, 32'h040);

      // ---------------- overflow ----------------
      for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
      ld(TXS);
      check("full_txstat", load_data, 32'h088);
      check("full_head", tx_data, 8'h30);
      drive(1'b1, TXD, 1'b1, 32'h0000_0039, 3'b001, 1'b1);
      ld(TXS);
      check("ovf_txstat", load_data, 32'h107);
      for (int i = 0; i < 7; i++) begin
         idle(1'b1);
         check($sformatf("ovf_drain%0d_valid", i), tx_valid, 1);
         check($sformatf("ovf_drain%0d_data", i), tx_data, 32'h31 + i);
      end
      ld(TXS);
      check("ovf_empty_valid", tx_valid, 0);
      check("ovf_empty_txstat", load_data, 32'h140);
      drive(1'b1, TXS, 1'b1, 32'h0, 3'b100, 1'b0);
      ld(TXS);
      check("ovf_cleared", load_data, 32'h040);

      // ---------------- simultaneous push and pop ----------------
      push(8'h61);
      drive(1'b1, TXD, 1'b1, 32'h0000_0062, 3'b001, 1'b1);
      ld(TXS);
      check("pushpop_txstat", load_data, 32'h001);
      check("pushpop_head", tx_data, 8'h62);
      idle(1'b1);
      ld(TXS);
      check("pushpop_drained", load_data, 32'h040);

      // ---------------- mtime carry from LO into HI ----------------
      @(negedge clk);
      force dut.mtime = 64'h0000_0000_FFFF_FFFF;
      adr_v = 1'b1; is_store = 1'b0; adr = MLO; tx_ready = 1'b0;
      #1;
      check("forced_lo", load_data, 32'hFFFF_FFFF);
      @(negedge clk);
      adr = MHI;
      #1;
      check("forced_hi", load_data, 32'h0);
      @(negedge clk);
      release dut.mtime;
      seen = 1'b0;
      lo   = 32'hDEAD_DEAD;
      for (int i = 0; i < 12 && !seen; i++) begin
         ld(MLO);
         if (load_data != 32'hFFFF_FFFF) begin
            seen = 1'b1;
            lo   = load_data;
         end
      end
      check("carry_seen", seen, 1);
      check("carry_lo", lo, 32'h0);
      ld(MHI);
      check("carry_hi", load_data, 32'h1);

      // ---------------- reset mid-operation ----------------
      for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
      ld(TXS);
      check("pre_reset_txstat", load_data, 32'h005);
      @(negedge clk);
      reset = 1'b1;
      adr_v = 1'b1; is_store = 1'b0; adr = MLO; tx_ready = 1'b0;
      #1;
      check("async_rst_valid", tx_valid, 0);
      check("async_rst_data", tx_data, 0);
      check("async_rst_mtime", load_data, 0);
      @(negedge clk);
      reset = 1'b0;
      adr = TXS;
      #1;
      check("post_rst_txstat", load_data, 32'h040);
      ld(MHI);
      check("post_rst_hi", load_data, 0);
      ld(MLO);
      ld(MLO);
      check("post_rst_lo_3", load_data, 0);
      ld(MLO);
      check("post_rst_lo_4", load_data, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's execute-stage memory port. It accepts one load or store request per cycle and returns load data in the same cycle, from a word-organised RAM or a small MMIO window. The MMIO window holds a console TX FIFO (with a ready/valid drain port) and a free-running 64-bit `mtime` counter. It sits outside the core, on the other end of the `adr_v`/`adr`/`is_store`/`store_data`/`access_size`/`load_data` interface.

## Interface
- `XLEN`, 32: data/address width.
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of 2.
- `MMIO_BASE`, 32'h1000_0000: base of the MMIO window, 16 bytes.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, ≥2.
- `TICK_DIV`, 1: clock cycles per `mtime` increment; ≥1.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `adr_v_i`  in  1  request valid.
- `adr_i`  in  XLEN  byte address.
- `is_store_i`  in  1  1 = store, 0 = load.
- `store_data_i`  in  XLEN  store data, right-aligned (unshifted register value).
- `access_size_i`  in  3  one-hot size: 001 byte, 010 half, 100 word.
- `load_data_o`  out  XLEN  aligned 32-bit word containing `adr_i`; combinational.
- `access_fault_o`  out  1  request valid and address unmapped; combinational.
- `tx_valid_o`  out  1  FIFO head valid.
- `tx_data_o`  out  8  FIFO head byte.
- `tx_ready_i`  in  1  consumer accepts head.

## Operation
- **Decode**
  - RAM hit: `adr_i < RAM_WORDS*4`.
  - MMIO hit: `adr_i[XLEN-1:4] == MMIO_BASE[XLEN-1:4]`.
  - Anything else is unmapped: `access_fault_o` = 1, load data 0, stores ignored.
- **Loads**
  - `load_data_o` returns the whole aligned word at `adr_i[XLEN-1:2]`; the LSU extracts and extends.
  - `load_data_o` is 0 when `adr_v_i` = 0.
- **Stores**
  - Byte-lane enables come from size and `adr_i[1:0]`:
    - byte: lane `adr[1:0]`.
    - half: lanes {`adr[1]`*2, `adr[1]`*2+1}; `adr[0]` ignored.
    - word: all lanes; `adr[1:0]` ignored.
  - Data is shifted into lane position before the write.
  - Other bytes of the word are preserved.
  - Illegal `access_size_i` encodings (not one-hot) write nothing.
- **MMIO offsets** (`adr_i[3:2]`)
  - 0 TXDATA:
    - Store pushes the byte in lane `adr[1:0]` as selected above (for word/half stores, that is `store_data_i[7:0]`).
    - If the FIFO is full, the byte is dropped and the sticky `ovf` bit is set.
    - Load returns 0.
  - 1 TXSTAT:
    - Load returns {zeros, `ovf`[8], `full`[7], `empty`[6], `count`[5:0]}.
    - Any store clears `ovf`.
  - 2 MTIME_LO: load `mtime[31:0]`; stores ignored.
  - 3 MTIME_HI: load `mtime[63:32]`; stores ignored.
- **TX FIFO**
  - Circular buffer with read/write pointers and a count.
  - `tx_valid_o` = ~empty; `tx_data_o` = entry at the read pointer.
  - Pop when `tx_valid_o & tx_ready_i`.
  - Simultaneous push and pop: both occur and count is unchanged.
  - The full check uses the pre-edge count, so a push to a full FIFO is dropped even if a pop happens in the same cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **mtime**
  - A prescaler counts 0..`TICK_DIV`-1; `mtime` increments when the prescaler is at `TICK_DIV`-1.
  - `mtime` wraps at 2^64 − 1 to 0.

## Timing
- Load: zero latency; `load_data_o` and `access_fault_o` are valid in the request cycle.
- Store: committed at the rising edge that ends the request cycle. A load to the same address in the next cycle returns the new data.
- TX push at edge N: `tx_valid_o` = 1 from cycle N+1. TXSTAT read in cycle N+1 shows the new count.
- Pop at edge N: next head (or `tx_valid_o` = 0) from cycle N+1.
- `tx_valid_o`/`tx_data_o` are stable while `tx_valid_o & ~tx_ready_i`.
- Reset values:
  - `tx_valid_o` = 0, `tx_data_o` = 0.
  - `ovf` = 0, `count` = 0, both pointers = 0.
  - `mtime` = 0, prescaler = 0.
  - RAM contents are not reset.
- Reset asserted mid-operation: FIFO empties and `mtime` clears immediately (asynchronous). A store in flight at the reset edge is not guaranteed to commit.
- No back-pressure on the request port; the responder accepts every cycle.

## Test plan
- Word store 0xDEADBEEF @0x10, then byte store 0x55 @0x12, then word load @0x10 → 0xDE55BEEF; half store 0x1234 @0x12 then load → 0x1234BEEF.
- Push 'A','B','C' to TXDATA with `tx_ready_i` = 0 → TXSTAT = 0x003; raise ready → `tx_data_o` 0x41, 0x42, 0x43 on consecutive cycles, then `tx_valid_o` = 0 and TXSTAT = 0x040.
- Fill FIFO (8 pushes), push a ninth with a pop in the same cycle → ninth dropped, TXSTAT `ovf` = 1, count 7; store to TXSTAT → `ovf` = 0.
- With `TICK_DIV` = 4, read MTIME_LO 40 cycles after reset release → 10. Force `mtime` to 0xFFFF_FFFF low, then read across the carry → HI increments by 1 and LO = 0.
- Load/store @0x2000_0000 → `access_fault_o` = 1, load data 0, RAM and FIFO unchanged.
- Assert reset with FIFO at count 5 and `mtime` ≠ 0 → same cycle `tx_valid_o` = 0; after release, TXSTAT = 0x040 and `mtime` restarts from 0.
